// File: rtl/mips_pkg.sv
// Shared pipeline types: register-index width, in-flight destination entry, interlock FSM states.
// Ports: none (package).
// Imported by the hazard interlock controller and its match encoder.
package mips_pkg;

  localparam int REGISTERWIDTH = 5;

  // One tracked producer: valid bit plus the destination register it will write.
  typedef struct packed {
    logic                     valid;
    logic [REGISTERWIDTH-1:0] rd;
  } rd_entry_t;

  typedef enum logic {
    HZ_RUN,
    HZ_STALL
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_rd_match_encoder.sv
// Combinational match of decode-stage sources against in-flight destinations.
// Ports: entries (packed array, index 0 = youngest), rs1/rs2 + use bits in; any_hit and stall count c out.
// The youngest matching producer wins, since it needs the longest wait: c = DEPTH - index.
module rd_match_encoder
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  rd_entry_t [DEPTH-1:0]          entries,
  input  logic [REGISTERWIDTH-1:0]       rs1,
  input  logic [REGISTERWIDTH-1:0]       rs2,
  input  logic                           use_rs1,
  input  logic                           use_rs2,
  output logic                           any_hit,
  output logic [$clog2(DEPTH+1)-1:0]     stall_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  // Walk from oldest to youngest so the lowest matching index is the last writer.
  always_comb begin
    any_hit   = 1'b0;
    stall_cnt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries[i].valid &&
          ((use_rs1 && (rs1 == entries[i].rd)) ||
           (use_rs2 && (rs2 == entries[i].rd)))) begin
        any_hit   = 1'b1;
        stall_cnt = CW'(DEPTH - i);
      end
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use/RAW interlock for a no-forwarding 5-stage pipe: tracks in-flight rd values and stalls ID.
// Ports: clk/reset (sync, active-high), pipe_en, flush, ID-stage operand info in;
//        stall/bubble (combinational), stall_remain, saturating stall_cycles statistic out.
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pipe_en,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [REGISTERWIDTH-1:0]     id_rs1,
  input  logic [REGISTERWIDTH-1:0]     id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic                         id_wr_en,
  input  logic [REGISTERWIDTH-1:0]     id_rd,
  output logic                         stall,
  output logic                         bubble,
  output logic [$clog2(DEPTH+1)-1:0]   stall_remain,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int CW = $clog2(DEPTH+1);

  rd_entry_t [DEPTH-1:0] ent_q;
  hz_state_e             state_q, state_nxt;
  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic                  any_hit;
  logic [CW-1:0]         hit_c;
  logic                  issue_wr;

  rd_match_encoder #(.DEPTH(DEPTH)) u_match (
    .entries   (ent_q),
    .rs1       (id_rs1),
    .rs2       (id_rs2),
    .use_rs1   (id_use_rs1),
    .use_rs2   (id_use_rs2),
    .any_hit   (any_hit),
    .stall_cnt (hit_c)
  );

  // Hits are only consulted in RUN; once in STALL the owed count alone drives the hold.
  // A flushed ID slot never stalls, it is discarded.
  assign stall  = ~flush & ((state_q == HZ_STALL) |
                            ((state_q == HZ_RUN) & id_valid & any_hit));
  assign bubble = stall;
  assign stall_remain = (state_q == HZ_STALL) ? cnt_q : '0;

  // Register 0 is never recorded, so it can never cause a hit.
  assign issue_wr = id_valid & ~stall & ~flush & id_wr_en & (id_rd != '0);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (flush) begin
      state_nxt = HZ_RUN;
      cnt_nxt   = '0;
    end else if (pipe_en) begin
      case (state_q)
        HZ_RUN: begin
          // c==1 needs no FSM help: the shift moves the producer into WB next cycle.
          if (stall && (hit_c > CW'(1))) begin
            state_nxt = HZ_STALL;
            cnt_nxt   = hit_c - CW'(1);
          end
        end
        HZ_STALL: begin
          if (cnt_q == CW'(1)) begin
            state_nxt = HZ_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q - CW'(1);
          end
        end
        default: begin
          state_nxt = HZ_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Older entries keep moving on a flush: they belong to instructions ahead of the branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '0;
    end else if (flush || pipe_en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        ent_q[i] <= ent_q[i-1];
      end
      ent_q[0].valid <= issue_wr;
      ent_q[0].rd    <= issue_wr ? id_rd : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && pipe_en && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int SRW   = $clog2(DEPTH+1);
  localparam int STAT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             pipe_en;
  logic             flush;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_wr_en;
  logic             stall, bubble;
  logic [SRW-1:0]   stall_remain;
  logic [CNT_W-1:0] stall_cycles;

  hazard_stall_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_en      (pipe_en),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_wr_en     (id_wr_en),
    .id_rd        (id_rd),
    .stall        (stall),
    .bubble       (bubble),
    .stall_remain (stall_remain),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: list of producers still ahead of WB (index 0 youngest), cycles still owed, stat count.
  int m_v  [DEPTH];
  int m_rd [DEPTH];
  int m_owed;
  int m_stat;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int model_c();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i] != 0 &&
          ((id_use_rs1 && int'(id_rs1) == m_rd[i]) ||
           (id_use_rs2 && int'(id_rs2) == m_rd[i])))
        return DEPTH - i;
    end
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i]  = 0;
      m_rd[i] = 0;
    end
    m_owed = 0;
    m_stat = 0;
  endtask

  // One clock: compare at negedge, then advance the reference across the posedge.
  task automatic step();
    int c;
    bit es;
    @(negedge clk);
    c  = model_c();
    es = !flush && ((m_owed > 0) || (id_valid && c > 0));
    chk("stall",        int'(stall),        int'(es));
    chk("bubble",       int'(bubble),       int'(es));
    chk("stall_remain", int'(stall_remain), m_owed);
    chk("stall_cycles", int'(stall_cycles), m_stat);
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (es && pipe_en && m_stat < STAT_MAX) m_stat++;
      if (flush || pipe_en) begin
        if (flush)           m_owed = 0;
        else if (m_owed > 0) m_owed = m_owed - 1;
        else if (es)         m_owed = c - 1;
        for (int i = DEPTH - 1; i > 0; i--) begin
          m_v[i]  = m_v[i-1];
          m_rd[i] = m_rd[i-1];
        end
        m_v[0]  = (id_valid && !es && !flush && id_wr_en && id_rd != 0) ? 1 : 0;
        m_rd[0] = int'(id_rd);
      end
    end
    #1;
  endtask

  task automatic ins(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                     input bit we, input int rd);
    id_valid   = v;
    id_rs1     = 5'(r1);
    id_rs2     = 5'(r2);
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_wr_en   = we;
    id_rd      = 5'(rd);
  endtask

  task automatic idle();
    ins(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1; pipe_en = 1; flush = 0;
    idle();
    step();
    step();
    reset = 0;
  endtask

  // add r3 ; sub r5,r3,r4
  task automatic add_r3();  ins(1, 1, 2, 1, 1, 1, 3); endtask
  task automatic sub_r3();  ins(1, 3, 4, 1, 1, 1, 5); endtask

  initial begin
    model_clear();
    do_reset();

    // Reset state
    idle(); #2;
    chk("rst_stall",   int'(stall), 0);
    chk("rst_remain",  int'(stall_remain), 0);
    chk("rst_cycles",  int'(stall_cycles), 0);
    step();

    // 1: back-to-back dependency, two stall cycles
    add_r3(); step();
    sub_r3(); #2;
    chk("t1_stall_a",  int'(stall), 1);
    chk("t1_remain_a", int'(stall_remain), 0);
    step(); #2;
    chk("t1_stall_b",  int'(stall), 1);
    chk("t1_remain_b", int'(stall_remain), 1);
    step(); #2;
    chk("t1_stall_c",  int'(stall), 0);
    chk("t1_cycles",   int'(stall_cycles), 2);
    step();
    idle(); step();

    // 2: one independent instruction in between, single stall
    do_reset();
    add_r3(); step();
    ins(1, 7, 8, 1, 1, 1, 6); step();
    sub_r3(); #2;
    chk("t2_stall_a",  int'(stall), 1);
    chk("t2_remain_a", int'(stall_remain), 0);
    step(); #2;
    chk("t2_stall_b",  int'(stall), 0);
    chk("t2_cycles",   int'(stall_cycles), 1);
    step();

    // 3: r0 never tracked; unused rs2 never matches
    do_reset();
    ins(1, 1, 2, 1, 1, 1, 0); step();
    ins(1, 0, 0, 1, 1, 1, 9); #2;
    chk("t3_r0", int'(stall), 0);
    step();
    ins(1, 5, 9, 1, 0, 1, 10); #2;
    chk("t3_unused_rs2", int'(stall), 0);
    step();

    // 4: flush on the first STALL cycle
    do_reset();
    add_r3(); step();
    sub_r3(); step();
    flush = 1; #2;
    chk("t4_flush_stall", int'(stall), 0);
    step();
    flush = 0;
    ins(1, 3, 2, 1, 1, 1, 11); #2;
    chk("t4_after_stall",  int'(stall), 0);
    chk("t4_after_remain", int'(stall_remain), 0);
    step();

    // 5: pipe frozen mid-stall
    do_reset();
    add_r3(); step();
    sub_r3(); step();
    pipe_en = 0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t5_frz_stall",  int'(stall), 1);
      chk("t5_frz_remain", int'(stall_remain), 1);
      chk("t5_frz_cycles", int'(stall_cycles), 1);
      step();
    end
    pipe_en = 1; #2;
    chk("t5_resume_stall", int'(stall), 1);
    step(); #2;
    chk("t5_done_stall",  int'(stall), 0);
    chk("t5_done_cycles", int'(stall_cycles), 2);
    step();

    // 6: reset during STALL
    do_reset();
    add_r3(); step();
    sub_r3(); step();
    reset = 1; step();
    reset = 0; idle(); #2;
    chk("t6_stall",  int'(stall), 0);
    chk("t6_remain", int'(stall_remain), 0);
    chk("t6_cycles", int'(stall_cycles), 0);
    step();
    sub_r3(); #2;
    chk("t6_no_entries", int'(stall), 0);
    step();

    // Saturation of the statistic
    do_reset();
    for (int k = 0; k < 10; k++) begin
      add_r3(); step();
      sub_r3(); step(); step();
    end
    add_r3(); step();
    sub_r3(); step(); #2;
    chk("sat_stall",  int'(stall), 1);
    chk("sat_cycles", int'(stall_cycles), STAT_MAX);
    step();
    idle(); step();

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset   = ($urandom % 200) == 0;
      pipe_en = ($urandom % 5) != 0;
      flush   = ($urandom % 20) == 0;
      ins(($urandom % 10) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom % 2, $urandom % 2, ($urandom % 4) != 0, $urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
